// File: rtl/hwpf_stride_pkg.sv
// Shared types and constants for the stride prefetcher configuration path.
package hwpf_stride_pkg;

   localparam int HWPF_CFG_WORD_W = 64;

   typedef enum logic [1:0] {
      BASE     = 2'd0,
      PARAM    = 2'd1,
      THROTTLE = 2'd2
   } hwpf_cfg_sel_e;

   typedef struct packed {
      logic [HWPF_CFG_WORD_W-1:0] base;
      logic [HWPF_CFG_WORD_W-1:0] param;
      logic [HWPF_CFG_WORD_W-1:0] throttle;
   } hwpf_stride_cfg_t;

   typedef struct packed {
      logic [HWPF_CFG_WORD_W-1:0] rdata;
      logic                       error;
   } hwpf_cfg_rsp_t;

   localparam hwpf_cfg_rsp_t HWPF_CFG_RSP_ERR = '{rdata: '0, error: 1'b1};

endpackage

// File: rtl/hwpf_stride_cfg_regs_if.sv
// Request/response channel between a configuration master and the stride register bank.
interface hwpf_stride_cfg_regs_if
   import hwpf_stride_pkg::*;
#(
   parameter int ADDR_W = 5
) ();
   logic                       cfg_req_valid;
   logic                       cfg_req_ready;
   logic                       cfg_req_we;
   logic [ADDR_W-1:0]          cfg_req_addr;
   logic [HWPF_CFG_WORD_W-1:0] cfg_req_wdata;
   logic                       cfg_rsp_valid;
   logic                       cfg_rsp_ready;
   logic [HWPF_CFG_WORD_W-1:0] cfg_rsp_rdata;
   logic                       cfg_rsp_error;

   modport master (
      output cfg_req_valid, cfg_req_we, cfg_req_addr, cfg_req_wdata, cfg_rsp_ready,
      input  cfg_req_ready, cfg_rsp_valid, cfg_rsp_rdata, cfg_rsp_error
   );

   modport slave (
      input  cfg_req_valid, cfg_req_we, cfg_req_addr, cfg_req_wdata, cfg_rsp_ready,
      output cfg_req_ready, cfg_rsp_valid, cfg_rsp_rdata, cfg_rsp_error
   );
endinterface

// File: rtl/hwpf_cfg_rsp_buf.sv
// One-entry valid/ready response holding register; a push may replace an entry popped in the same cycle.
module hwpf_cfg_rsp_buf
   import hwpf_stride_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  hwpf_cfg_rsp_t push_rsp,
   input  logic          pop,
   output logic          req_ready,
   output logic          rsp_valid,
   output hwpf_cfg_rsp_t rsp
);
   logic          vld_p1;
   hwpf_cfg_rsp_t rsp_p1;

   assign req_ready = !vld_p1 || pop;
   assign rsp_valid = vld_p1;
   assign rsp       = rsp_p1;

   // Stage p1: held response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1 <= 1'b0;
         rsp_p1 <= '0;
      end else if (push) begin
         vld_p1 <= 1'b1;
         rsp_p1 <= push_rsp;
      end else if (pop) begin
         vld_p1 <= 1'b0;
      end
   end
endmodule

// File: rtl/hwpf_stride_cfg_regs.sv
// Memory-mapped base/param/throttle register bank for the stride prefetch engines.
module hwpf_stride_cfg_regs
   import hwpf_stride_pkg::*;
#(
   parameter  int NUM_HW_PREFETCH = 4,
   localparam int ADDR_W          = $clog2(NUM_HW_PREFETCH + 1) + 2
) (
   input  logic                                    clk_i,
   input  logic                                    rst_i,
   hwpf_stride_cfg_regs_if.slave                   cfg,
   output logic             [NUM_HW_PREFETCH-1:0]  base_set_o,
   output logic             [NUM_HW_PREFETCH-1:0]  param_set_o,
   output logic             [NUM_HW_PREFETCH-1:0]  throttle_set_o,
   output hwpf_stride_cfg_t [NUM_HW_PREFETCH-1:0]  hwpf_stride_cfg_o,
   input  logic             [HWPF_CFG_WORD_W-1:0]  hwpf_stride_status_i
);
   localparam int ENG_W = ADDR_W - 2;

   logic                                   accept;
   logic             [ENG_W-1:0]           eng;
   logic             [1:0]                 sel;
   logic                                   reg_hit;
   logic                                   status_hit;
   logic             [NUM_HW_PREFETCH-1:0] base_we;
   logic             [NUM_HW_PREFETCH-1:0] param_we;
   logic             [NUM_HW_PREFETCH-1:0] throttle_we;
   hwpf_cfg_rsp_t                          rsp_p0;
   hwpf_cfg_rsp_t                          rsp_q;
   hwpf_stride_cfg_t [NUM_HW_PREFETCH-1:0] cfg_p1;
   logic             [NUM_HW_PREFETCH-1:0] base_set_p1;
   logic             [NUM_HW_PREFETCH-1:0] param_set_p1;
   logic             [NUM_HW_PREFETCH-1:0] throttle_set_p1;

   assign accept     = cfg.cfg_req_valid && cfg.cfg_req_ready;
   assign eng        = cfg.cfg_req_addr[ADDR_W-1:2];
   assign sel        = cfg.cfg_req_addr[1:0];
   assign reg_hit    = (int'(eng) < NUM_HW_PREFETCH) && (sel != 2'd3);
   assign status_hit = (int'(eng) == NUM_HW_PREFETCH) && (sel == 2'd0);

   // Stage p0: decode and response formation in the accept cycle
   always_comb begin
      base_we     = '0;
      param_we    = '0;
      throttle_we = '0;
      for (int e = 0; e < NUM_HW_PREFETCH; e++) begin
         if (accept && cfg.cfg_req_we && reg_hit && int'(eng) == e) begin
            base_we[e]     = (sel == BASE);
            param_we[e]    = (sel == PARAM);
            throttle_we[e] = (sel == THROTTLE);
         end
      end
   end

   always_comb begin
      rsp_p0 = HWPF_CFG_RSP_ERR;
      if (cfg.cfg_req_we) begin
         if (reg_hit) rsp_p0 = '0;
      end else if (status_hit) begin
         rsp_p0 = '{rdata: hwpf_stride_status_i, error: 1'b0};
      end else if (reg_hit) begin
         rsp_p0 = '0;
         for (int e = 0; e < NUM_HW_PREFETCH; e++) begin
            if (int'(eng) == e) begin
               case (sel)
                  BASE:     rsp_p0.rdata = cfg_p1[e].base;
                  PARAM:    rsp_p0.rdata = cfg_p1[e].param;
                  THROTTLE: rsp_p0.rdata = cfg_p1[e].throttle;
                  default:  rsp_p0.rdata = '0;
               endcase
            end
         end
      end
   end

   // Stage p1: register contents and their update pulses
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cfg_p1          <= '0;
         base_set_p1     <= '0;
         param_set_p1    <= '0;
         throttle_set_p1 <= '0;
      end else begin
         base_set_p1     <= base_we;
         param_set_p1    <= param_we;
         throttle_set_p1 <= throttle_we;
         for (int e = 0; e < NUM_HW_PREFETCH; e++) begin
            if (base_we[e])     cfg_p1[e].base     <= cfg.cfg_req_wdata;
            if (param_we[e])    cfg_p1[e].param    <= cfg.cfg_req_wdata;
            // Throttle keeps only the low word; bits [63:32] are always zero
            if (throttle_we[e]) cfg_p1[e].throttle <= {32'd0, cfg.cfg_req_wdata[31:0]};
         end
      end
   end

   hwpf_cfg_rsp_buf u_rsp_buf (
      .clk       (clk_i),
      .rst       (rst_i),
      .push      (accept),
      .push_rsp  (rsp_p0),
      .pop       (cfg.cfg_rsp_ready),
      .req_ready (cfg.cfg_req_ready),
      .rsp_valid (cfg.cfg_rsp_valid),
      .rsp       (rsp_q)
   );

   assign cfg.cfg_rsp_rdata = rsp_q.rdata;
   assign cfg.cfg_rsp_error = rsp_q.error;
   assign base_set_o        = base_set_p1;
   assign param_set_o       = param_set_p1;
   assign throttle_set_o    = throttle_set_p1;
   assign hwpf_stride_cfg_o = cfg_p1;
endmodule
